// File: rtl/usb_desc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | usb_desc_pkg : shared descriptor type codes, string indices, FSM state    |
// |                encoding and the EP0 max-packet legality check.            |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
package usb_desc_pkg;

  localparam logic [7:0] C_DT_DEV   = 8'd1;
  localparam logic [7:0] C_DT_CFG   = 8'd2;
  localparam logic [7:0] C_DT_STR   = 8'd3;
  localparam logic [7:0] C_DT_QUAL  = 8'd6;
  localparam logic [7:0] C_DT_OSCFG = 8'd7;

  localparam logic [7:0] C_STR_LANG    = 8'd0;
  localparam logic [7:0] C_STR_VENDOR  = 8'd1;
  localparam logic [7:0] C_STR_PRODUCT = 8'd2;
  localparam logic [7:0] C_STR_SERIAL  = 8'd3;
  localparam logic [7:0] C_STR_LANG_LEN = 8'd4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_IN  = 3'd1,
    ST_SEND     = 3'd2,
    ST_WAIT_ACK = 3'd3,
    ST_ZLP      = 3'd4
  } state_t;

  function automatic logic max_pkt_legal(input int unsigned mp);
    return (mp == 8) || (mp == 16) || (mp == 32) || (mp == 64);
  endfunction

endpackage
`default_nettype wire

// File: rtl/usb_desc_lookup.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | usb_desc_lookup : combinational wValue -> {addr, len, valid, subst}        |
// |                   resolver over the descriptor ROM layout outputs.        |
// | Revision        : 1.0                                                      |
// +----------------------------------------------------------------------------+
module usb_desc_lookup
  import usb_desc_pkg::*;
#(
  parameter bit HSSUPPORT = 1'b1
) (
  input  logic [7:0] i_type,
  input  logic [7:0] i_index,
  input  logic       i_hs_mode,
  input  logic       i_have_strings,
  input  logic [9:0] i_dev_addr,
  input  logic [7:0] i_dev_len,
  input  logic [9:0] i_qual_addr,
  input  logic [7:0] i_qual_len,
  input  logic [9:0] i_fscfg_addr,
  input  logic [7:0] i_fscfg_len,
  input  logic [9:0] i_hscfg_addr,
  input  logic [7:0] i_hscfg_len,
  input  logic [9:0] i_strlang_addr,
  input  logic [9:0] i_strvendor_addr,
  input  logic [7:0] i_strvendor_len,
  input  logic [9:0] i_strproduct_addr,
  input  logic [7:0] i_strproduct_len,
  input  logic [9:0] i_strserial_addr,
  input  logic [7:0] i_strserial_len,
  output logic [9:0] o_addr,
  output logic [7:0] o_len,
  output logic       o_valid,
  output logic       o_subst
);

  always_comb begin
    o_addr  = '0;
    o_len   = '0;
    o_valid = 1'b0;
    o_subst = 1'b0;
    case (i_type)
      C_DT_DEV: begin
        o_addr  = i_dev_addr;
        o_len   = i_dev_len;
        o_valid = 1'b1;
      end
      C_DT_CFG: begin
        o_addr  = i_hs_mode ? i_hscfg_addr : i_fscfg_addr;
        o_len   = i_hs_mode ? i_hscfg_len  : i_fscfg_len;
        o_valid = (i_index == 8'd0);
      end
      C_DT_STR: begin
        case (i_index)
          C_STR_LANG:    begin o_addr = i_strlang_addr;    o_len = C_STR_LANG_LEN;   end
          C_STR_VENDOR:  begin o_addr = i_strvendor_addr;  o_len = i_strvendor_len;  end
          C_STR_PRODUCT: begin o_addr = i_strproduct_addr; o_len = i_strproduct_len; end
          C_STR_SERIAL:  begin o_addr = i_strserial_addr;  o_len = i_strserial_len;  end
          default: ;
        endcase
        // Unknown indices leave len at zero, which also rejects them here.
        o_valid = i_have_strings && (o_len != 8'd0);
      end
      C_DT_QUAL: begin
        o_addr  = i_qual_addr;
        o_len   = i_qual_len;
        o_valid = HSSUPPORT;
      end
      C_DT_OSCFG: begin
        o_addr  = i_hs_mode ? i_fscfg_addr : i_hscfg_addr;
        o_len   = i_hs_mode ? i_fscfg_len  : i_hscfg_len;
        o_valid = HSSUPPORT && (i_index == 8'd0);
        o_subst = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/usb_getdesc_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | usb_getdesc_ctrl : EP0 GET_DESCRIPTOR data stage; streams ROM bytes to the |
// |                    IN transmitter in max-packet chunks with ACK/retry/ZLP.|
// | Revision         : 1.0                                                     |
// +----------------------------------------------------------------------------+
module usb_getdesc_ctrl
  import usb_desc_pkg::*;
#(
  parameter int unsigned MAX_PKT   = 64,
  parameter bit          HSSUPPORT = 1'b1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        i_get_desc,
  input  logic [15:0] i_wvalue,
  input  logic [15:0] i_wlength,
  input  logic        i_hs_mode,
  input  logic        i_setup_abort,
  input  logic [9:0]  i_desc_dev_addr,
  input  logic [7:0]  i_desc_dev_len,
  input  logic [9:0]  i_desc_qual_addr,
  input  logic [7:0]  i_desc_qual_len,
  input  logic [9:0]  i_desc_fscfg_addr,
  input  logic [7:0]  i_desc_fscfg_len,
  input  logic [9:0]  i_desc_hscfg_addr,
  input  logic [7:0]  i_desc_hscfg_len,
  input  logic [9:0]  i_desc_oscfg_addr,
  input  logic [9:0]  i_desc_strlang_addr,
  input  logic [9:0]  i_desc_strvendor_addr,
  input  logic [7:0]  i_desc_strvendor_len,
  input  logic [9:0]  i_desc_strproduct_addr,
  input  logic [7:0]  i_desc_strproduct_len,
  input  logic [9:0]  i_desc_strserial_addr,
  input  logic [7:0]  i_desc_strserial_len,
  input  logic        i_descrom_have_strings,
  output logic [9:0]  o_descrom_raddr,
  input  logic [7:0]  i_descrom_rdat,
  input  logic        i_in_token,
  output logic        o_tx_valid,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_last,
  input  logic        i_tx_ready,
  output logic        o_tx_zlp,
  input  logic        i_in_ack,
  input  logic        i_in_retry,
  output logic        o_stall,
  output logic        o_busy
);

  localparam logic [15:0] C_MAX_PKT16 = 16'(MAX_PKT);
  localparam logic [7:0]  C_MAX_PKT8  = 8'(MAX_PKT);

  generate
    if (!max_pkt_legal(MAX_PKT)) begin : g_bad_max_pkt
      $error("usb_getdesc_ctrl: MAX_PKT must be 8, 16, 32 or 64");
    end
  endgenerate

  logic [9:0]  w_lu_addr;
  logic [7:0]  w_lu_len;
  logic        w_lu_valid;
  logic        w_lu_subst;
  logic [15:0] w_xfer16;
  logic        w_need_zlp;
  logic        w_start;
  logic        w_accept;
  logic [7:0]  w_remaining;
  logic [7:0]  w_pkt_size;
  logic [7:0]  w_last_off;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [9:0]  r_desc_addr;
  logic [9:0]  r_osc_addr;
  logic [7:0]  r_xfer_len;
  logic [7:0]  r_pkt_base;
  logic [7:0]  r_offset;
  logic        r_subst;
  logic        r_need_zlp;
  logic        r_zlp_inflight;
  logic        r_stall;

  usb_desc_lookup #(
    .HSSUPPORT (HSSUPPORT)
  ) u_lookup (
    .i_type            (i_wvalue[15:8]),
    .i_index           (i_wvalue[7:0]),
    .i_hs_mode         (i_hs_mode),
    .i_have_strings    (i_descrom_have_strings),
    .i_dev_addr        (i_desc_dev_addr),
    .i_dev_len         (i_desc_dev_len),
    .i_qual_addr       (i_desc_qual_addr),
    .i_qual_len        (i_desc_qual_len),
    .i_fscfg_addr      (i_desc_fscfg_addr),
    .i_fscfg_len       (i_desc_fscfg_len),
    .i_hscfg_addr      (i_desc_hscfg_addr),
    .i_hscfg_len       (i_desc_hscfg_len),
    .i_strlang_addr    (i_desc_strlang_addr),
    .i_strvendor_addr  (i_desc_strvendor_addr),
    .i_strvendor_len   (i_desc_strvendor_len),
    .i_strproduct_addr (i_desc_strproduct_addr),
    .i_strproduct_len  (i_desc_strproduct_len),
    .i_strserial_addr  (i_desc_strserial_addr),
    .i_strserial_len   (i_desc_strserial_len),
    .o_addr            (w_lu_addr),
    .o_len             (w_lu_len),
    .o_valid           (w_lu_valid),
    .o_subst           (w_lu_subst)
  );

  assign w_xfer16   = ({8'h00, w_lu_len} < i_wlength) ? {8'h00, w_lu_len} : i_wlength;
  assign w_need_zlp = (w_xfer16 < i_wlength) && ((w_xfer16 % C_MAX_PKT16) == 16'd0) &&
                      (w_xfer16 != 16'd0);
  // A zero-length transfer (wLength 0 or empty descriptor) has no data stage.
  assign w_start    = w_lu_valid && (w_xfer16 != 16'd0);

  assign w_remaining = r_xfer_len - r_pkt_base;
  assign w_pkt_size  = (w_remaining > C_MAX_PKT8) ? C_MAX_PKT8 : w_remaining;
  assign w_last_off  = r_pkt_base + w_pkt_size - 8'd1;
  assign w_accept    = o_tx_valid && i_tx_ready;

  always_comb begin
    w_state_nxt = r_state;
    o_tx_valid  = 1'b0;
    o_tx_last   = 1'b0;
    o_tx_zlp    = 1'b0;
    if (i_setup_abort) begin
      w_state_nxt = ST_IDLE;
    end else if (i_get_desc) begin
      w_state_nxt = w_start ? ST_WAIT_IN : ST_IDLE;
    end else begin
      case (r_state)
        ST_WAIT_IN: begin
          if (i_in_token) begin
            if (w_remaining != 8'd0) w_state_nxt = ST_SEND;
            else if (r_need_zlp)     w_state_nxt = ST_ZLP;
          end
        end
        ST_SEND: begin
          o_tx_valid = 1'b1;
          o_tx_last  = (r_offset == w_last_off);
          if (i_tx_ready && o_tx_last) w_state_nxt = ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          if (i_in_ack) begin
            if (r_zlp_inflight)
              w_state_nxt = ST_IDLE;
            else if ((w_remaining != w_pkt_size) || r_need_zlp)
              w_state_nxt = ST_WAIT_IN;
            else
              w_state_nxt = ST_IDLE;
          end else if (i_in_retry) begin
            w_state_nxt = ST_WAIT_IN;
          end
        end
        ST_ZLP: begin
          o_tx_zlp    = 1'b1;
          w_state_nxt = ST_WAIT_ACK;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_desc_addr    <= '0;
      r_osc_addr     <= '0;
      r_xfer_len     <= '0;
      r_pkt_base     <= '0;
      r_offset       <= '0;
      r_subst        <= 1'b0;
      r_need_zlp     <= 1'b0;
      r_zlp_inflight <= 1'b0;
      r_stall        <= 1'b0;
    end else if (i_setup_abort) begin
      r_stall <= 1'b0;
    end else if (i_get_desc) begin
      r_stall        <= !w_lu_valid;
      r_desc_addr    <= w_lu_addr;
      r_osc_addr     <= i_desc_oscfg_addr;
      r_subst        <= w_lu_subst;
      r_xfer_len     <= w_xfer16[7:0];
      r_need_zlp     <= w_need_zlp;
      r_pkt_base     <= '0;
      r_offset       <= '0;
      r_zlp_inflight <= 1'b0;
    end else begin
      if (w_accept) r_offset <= r_offset + 8'd1;
      if (r_state == ST_ZLP) r_zlp_inflight <= 1'b1;
      if (r_state == ST_WAIT_ACK) begin
        if (i_in_ack) begin
          if (!r_zlp_inflight) r_pkt_base <= r_pkt_base + w_pkt_size;
        end else if (i_in_retry) begin
          r_offset <= r_pkt_base;
        end
      end
    end
  end

  // Other-speed config: the type byte comes from a ROM location holding 0x07.
  assign o_descrom_raddr = (r_subst && (r_offset == 8'd1)) ? r_osc_addr
                                                           : r_desc_addr + {2'b00, r_offset};
  assign o_tx_data = i_descrom_rdat;
  assign o_stall   = r_stall;
  assign o_busy    = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_usb_getdesc_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_usb_getdesc_ctrl : two DUTs (MAX_PKT 64/HS, MAX_PKT 8/no-HS) on a ROM  |
// |                       model, driven from a vector table plus sequences.   |
// | Revision            : 1.0                                                  |
// +----------------------------------------------------------------------------+
module tb_usb_getdesc_ctrl;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        i_get_desc = 1'b0;
  logic [15:0] i_wvalue = '0;
  logic [15:0] i_wlength = '0;
  logic        i_hs_mode = 1'b0;
  logic        i_setup_abort = 1'b0;
  logic        i_in_token = 1'b0;
  logic        i_tx_ready = 1'b1;
  logic        i_in_ack = 1'b0;
  logic        i_in_retry = 1'b0;

  logic [1:0]  tx_valid, tx_last, tx_zlp, stall, busy;
  logic [9:0]  raddr0, raddr1;
  logic [7:0]  rdat0, rdat1, tx_data0, tx_data1;
  logic [7:0]  rom_mem [1024];

  int n_checks = 0;
  int n_fail   = 0;
  int cur_vec  = -1;

  assign rdat0 = rom_mem[raddr0];
  assign rdat1 = rom_mem[raddr1];

  always #5 CLK = ~CLK;

  usb_getdesc_ctrl #(.MAX_PKT(64), .HSSUPPORT(1'b1)) u_dut64 (
    .CLK(CLK), .RESET(RESET), .i_get_desc(i_get_desc), .i_wvalue(i_wvalue),
    .i_wlength(i_wlength), .i_hs_mode(i_hs_mode), .i_setup_abort(i_setup_abort),
    .i_desc_dev_addr(10'h000), .i_desc_dev_len(8'd18),
    .i_desc_qual_addr(10'h020), .i_desc_qual_len(8'd10),
    .i_desc_fscfg_addr(10'h040), .i_desc_fscfg_len(8'd32),
    .i_desc_hscfg_addr(10'h080), .i_desc_hscfg_len(8'd36),
    .i_desc_oscfg_addr(10'h0C0), .i_desc_strlang_addr(10'h100),
    .i_desc_strvendor_addr(10'h110), .i_desc_strvendor_len(8'd10),
    .i_desc_strproduct_addr(10'h130), .i_desc_strproduct_len(8'd14),
    .i_desc_strserial_addr(10'h150), .i_desc_strserial_len(8'd0),
    .i_descrom_have_strings(1'b1), .o_descrom_raddr(raddr0), .i_descrom_rdat(rdat0),
    .i_in_token(i_in_token), .o_tx_valid(tx_valid[0]), .o_tx_data(tx_data0),
    .o_tx_last(tx_last[0]), .i_tx_ready(i_tx_ready), .o_tx_zlp(tx_zlp[0]),
    .i_in_ack(i_in_ack), .i_in_retry(i_in_retry), .o_stall(stall[0]), .o_busy(busy[0])
  );

  usb_getdesc_ctrl #(.MAX_PKT(8), .HSSUPPORT(1'b0)) u_dut8 (
    .CLK(CLK), .RESET(RESET), .i_get_desc(i_get_desc), .i_wvalue(i_wvalue),
    .i_wlength(i_wlength), .i_hs_mode(i_hs_mode), .i_setup_abort(i_setup_abort),
    .i_desc_dev_addr(10'h000), .i_desc_dev_len(8'd18),
    .i_desc_qual_addr(10'h020), .i_desc_qual_len(8'd10),
    .i_desc_fscfg_addr(10'h040), .i_desc_fscfg_len(8'd32),
    .i_desc_hscfg_addr(10'h080), .i_desc_hscfg_len(8'd36),
    .i_desc_oscfg_addr(10'h0C0), .i_desc_strlang_addr(10'h100),
    .i_desc_strvendor_addr(10'h110), .i_desc_strvendor_len(8'd10),
    .i_desc_strproduct_addr(10'h130), .i_desc_strproduct_len(8'd14),
    .i_desc_strserial_addr(10'h150), .i_desc_strserial_len(8'd0),
    .i_descrom_have_strings(1'b1), .o_descrom_raddr(raddr1), .i_descrom_rdat(rdat1),
    .i_in_token(i_in_token), .o_tx_valid(tx_valid[1]), .o_tx_data(tx_data1),
    .o_tx_last(tx_last[1]), .i_tx_ready(i_tx_ready), .o_tx_zlp(tx_zlp[1]),
    .i_in_ack(i_in_ack), .i_in_retry(i_in_retry), .o_stall(stall[1]), .o_busy(busy[1])
  );

  typedef struct {
    int          sel;
    logic        hs;
    logic [15:0] wv;
    logic [15:0] wl;
    logic        stall;
    logic [9:0]  base;
    logic        subst;
    int          xlen;
    logic        zlp;
  } vec_t;

  vec_t vecs [19];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec=%0d t=%0t actual=%0h expected=%0h", nm, cur_vec, $time, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input logic [9:0] base, input logic subst, input int k);
    if (subst && k == 1) return 8'h07;
    return rom_mem[base + 10'(k)];
  endfunction

  function automatic logic [7:0] sel_data(input int s);
    return (s == 1) ? tx_data1 : tx_data0;
  endfunction

  task automatic start_desc(input logic [15:0] wv, input logic [15:0] wl, input logic hs);
    @(negedge CLK);
    i_wvalue = wv; i_wlength = wl; i_hs_mode = hs; i_get_desc = 1'b1;
    @(negedge CLK);
    i_get_desc = 1'b0;
    #1;
  endtask

  task automatic pulse_in();
    @(negedge CLK); i_in_token = 1'b1;
    @(negedge CLK); i_in_token = 1'b0;
  endtask

  task automatic pulse_ack();
    @(negedge CLK); i_in_ack = 1'b1;
    @(negedge CLK); i_in_ack = 1'b0;
  endtask

  task automatic pulse_abort();
    @(negedge CLK); i_setup_abort = 1'b1;
    @(negedge CLK); i_setup_abort = 1'b0;
  endtask

  // One IN token, then collect one packet under a fixed ready pattern.
  task automatic run_packet(input int sel, input logic [9:0] base, input logic subst,
                            input int start, input int size);
    int got = 0;
    int cyc = 0;
    pulse_in();
    while (got < size && cyc < 64) begin
      i_tx_ready = (cyc % 3) != 2;
      #1;
      if (tx_valid[sel] && i_tx_ready) begin
        chk("data", {24'h0, sel_data(sel)}, {24'h0, exp_byte(base, subst, start + got)});
        chk("last", {31'h0, tx_last[sel]}, {31'h0, (got == size - 1)});
        got++;
      end
      cyc++;
      @(negedge CLK);
    end
    i_tx_ready = 1'b1;
    chk("pkt_len", got, size);
    #1;
    chk("valid_after_pkt", {31'h0, tx_valid[sel]}, 32'h0);
  endtask

  task automatic expect_zlp_end(input int sel);
    pulse_in();
    #1;
    chk("zlp_pulse", {31'h0, tx_zlp[sel]}, 32'h1);
    chk("zlp_no_valid", {31'h0, tx_valid[sel]}, 32'h0);
    @(negedge CLK); #1;
    chk("zlp_one_cycle", {31'h0, tx_zlp[sel]}, 32'h0);
    pulse_ack();
    #1;
    chk("idle_after_zlp", {31'h0, busy[sel]}, 32'h0);
  endtask

  task automatic run_vector(input vec_t v);
    int start;
    int size;
    int mp;
    mp = (v.sel == 1) ? 8 : 64;
    pulse_abort();
    start_desc(v.wv, v.wl, v.hs);
    if (v.stall) begin
      chk("stall_set", {31'h0, stall[v.sel]}, 32'h1);
      chk("stall_busy", {31'h0, busy[v.sel]}, 32'h0);
      pulse_in(); #1;
      chk("stall_no_tx", {31'h0, tx_valid[v.sel]}, 32'h0);
      pulse_abort(); #1;
      chk("stall_clear", {31'h0, stall[v.sel]}, 32'h0);
      return;
    end
    chk("no_stall", {31'h0, stall[v.sel]}, 32'h0);
    if (v.xlen == 0) begin
      chk("no_data_idle", {31'h0, busy[v.sel]}, 32'h0);
      pulse_in(); #1;
      chk("no_data_no_tx", {31'h0, tx_valid[v.sel]}, 32'h0);
      return;
    end
    chk("busy_start", {31'h0, busy[v.sel]}, 32'h1);
    start = 0;
    while (start < v.xlen) begin
      size = (v.xlen - start > mp) ? mp : v.xlen - start;
      run_packet(v.sel, v.base, v.subst, start, size);
      pulse_ack();
      start += size;
    end
    #1;
    if (v.zlp) begin
      chk("busy_before_zlp", {31'h0, busy[v.sel]}, 32'h1);
      expect_zlp_end(v.sel);
    end else begin
      chk("idle_at_end", {31'h0, busy[v.sel]}, 32'h0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] dev_b [18] = '{8'h12, 8'h01, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h40, 8'hAA,
                               8'h33, 8'h20, 8'h01, 8'h00, 8'h01, 8'h01, 8'h02, 8'h00, 8'h01};
    logic [7:0] fs_b [9]  = '{8'h09, 8'h02, 8'h20, 8'h00, 8'h01, 8'h01, 8'h00, 8'h80, 8'h00};
    logic [7:0] hs_b [4]  = '{8'h09, 8'h02, 8'h24, 8'h00};
    for (int i = 0; i < 1024; i++) rom_mem[i] = 8'((i * 7 + 3) ^ (i >> 3));
    for (int i = 0; i < 18; i++) rom_mem[i] = dev_b[i];
    for (int i = 0; i < 9; i++) rom_mem[10'h040 + i] = fs_b[i];
    for (int i = 0; i < 4; i++) rom_mem[10'h080 + i] = hs_b[i];
    rom_mem[10'h0C0] = 8'h07;

    //            sel hs    wValue    wLength  stall base     subst xlen zlp
    vecs[0]  = '{0, 1'b0, 16'h0100, 16'd64,  1'b0, 10'h000, 1'b0, 18, 1'b0};
    vecs[1]  = '{0, 1'b0, 16'h0100, 16'd8,   1'b0, 10'h000, 1'b0, 8,  1'b0};
    vecs[2]  = '{1, 1'b0, 16'h0200, 16'd255, 1'b0, 10'h040, 1'b0, 32, 1'b1};
    vecs[3]  = '{0, 1'b1, 16'h0700, 16'd255, 1'b0, 10'h040, 1'b1, 32, 1'b0};
    vecs[4]  = '{0, 1'b1, 16'h0200, 16'd255, 1'b0, 10'h080, 1'b0, 36, 1'b0};
    vecs[5]  = '{0, 1'b0, 16'h0300, 16'd255, 1'b0, 10'h100, 1'b0, 4,  1'b0};
    vecs[6]  = '{0, 1'b0, 16'h0302, 16'd255, 1'b0, 10'h130, 1'b0, 14, 1'b0};
    vecs[7]  = '{0, 1'b0, 16'h0305, 16'd255, 1'b1, 10'h000, 1'b0, 0,  1'b0};
    vecs[8]  = '{0, 1'b0, 16'h0201, 16'd255, 1'b1, 10'h000, 1'b0, 0,  1'b0};
    vecs[9]  = '{0, 1'b0, 16'h0400, 16'd255, 1'b1, 10'h000, 1'b0, 0,  1'b0};
    vecs[10] = '{0, 1'b0, 16'h0303, 16'd255, 1'b1, 10'h000, 1'b0, 0,  1'b0};
    vecs[11] = '{0, 1'b0, 16'h0600, 16'd10,  1'b0, 10'h020, 1'b0, 10, 1'b0};
    vecs[12] = '{1, 1'b0, 16'h0600, 16'd255, 1'b1, 10'h000, 1'b0, 0,  1'b0};
    vecs[13] = '{1, 1'b1, 16'h0700, 16'd255, 1'b1, 10'h000, 1'b0, 0,  1'b0};
    vecs[14] = '{0, 1'b0, 16'h0100, 16'd0,   1'b0, 10'h000, 1'b0, 0,  1'b0};
    vecs[15] = '{1, 1'b0, 16'h0100, 16'd16,  1'b0, 10'h000, 1'b0, 16, 1'b0};
    vecs[16] = '{1, 1'b0, 16'h0100, 16'd255, 1'b0, 10'h000, 1'b0, 18, 1'b0};
    vecs[17] = '{0, 1'b0, 16'h0301, 16'd255, 1'b0, 10'h110, 1'b0, 10, 1'b0};
    vecs[18] = '{0, 1'b0, 16'h0200, 16'd64,  1'b0, 10'h040, 1'b0, 32, 1'b0};

    #12;
    for (int s = 0; s < 2; s++) begin
      chk("rst_valid", {31'h0, tx_valid[s]}, 32'h0);
      chk("rst_last",  {31'h0, tx_last[s]},  32'h0);
      chk("rst_zlp",   {31'h0, tx_zlp[s]},   32'h0);
      chk("rst_stall", {31'h0, stall[s]},    32'h0);
      chk("rst_busy",  {31'h0, busy[s]},     32'h0);
    end
    chk("rst_raddr0", {22'h0, raddr0}, 32'h0);
    chk("rst_raddr1", {22'h0, raddr1}, 32'h0);
    @(negedge CLK);
    RESET = 1'b0;

    for (int i = 0; i < 19; i++) begin
      cur_vec = i;
      run_vector(vecs[i]);
    end

    // Retry after the 2nd packet, then simultaneous ack+retry (ack wins).
    cur_vec = 100;
    pulse_abort();
    start_desc(16'h0200, 16'd255, 1'b0);
    run_packet(1, 10'h040, 1'b0, 0, 8);
    pulse_ack();
    run_packet(1, 10'h040, 1'b0, 8, 8);
    @(negedge CLK); i_in_retry = 1'b1;
    @(negedge CLK); i_in_retry = 1'b0;
    i_tx_ready = 1'b1;
    pulse_in(); #1;
    chk("retry_first_byte", {24'h0, tx_data1}, 32'h00);
    chk("retry_raddr", {22'h0, raddr1}, 32'h048);
    @(negedge CLK);
    for (int k = 1; k < 8; k++) @(negedge CLK);
    pulse_ack();
    run_packet(1, 10'h040, 1'b0, 16, 8);
    @(negedge CLK); i_in_ack = 1'b1; i_in_retry = 1'b1;
    @(negedge CLK); i_in_ack = 1'b0; i_in_retry = 1'b0;
    run_packet(1, 10'h040, 1'b0, 24, 8);
    pulse_ack();
    expect_zlp_end(1);

    // New GET_DESCRIPTOR while busy restarts on the new descriptor.
    cur_vec = 101;
    pulse_abort();
    start_desc(16'h0100, 16'd255, 1'b0);
    start_desc(16'h0600, 16'd255, 1'b0);
    run_packet(0, 10'h020, 1'b0, 0, 10);
    pulse_ack(); #1;
    chk("restart_idle", {31'h0, busy[0]}, 32'h0);

    // Abort in the middle of SEND.
    cur_vec = 102;
    pulse_abort();
    start_desc(16'h0100, 16'd64, 1'b0);
    @(negedge CLK); i_in_token = 1'b1; i_tx_ready = 1'b0;
    @(negedge CLK); i_in_token = 1'b0; #1;
    chk("send_valid", {31'h0, tx_valid[0]}, 32'h1);
    chk("send_byte0", {24'h0, tx_data0}, 32'h12);
    @(negedge CLK); i_setup_abort = 1'b1; #1;
    chk("abort_drops_valid", {31'h0, tx_valid[0]}, 32'h0);
    @(negedge CLK); i_setup_abort = 1'b0; #1;
    chk("abort_busy", {31'h0, busy[0]}, 32'h0);
    chk("abort_valid", {31'h0, tx_valid[0]}, 32'h0);
    i_tx_ready = 1'b1;

    // Asynchronous reset mid-transfer.
    cur_vec = 103;
    start_desc(16'h0100, 16'd64, 1'b0);
    @(negedge CLK); i_in_token = 1'b1; i_tx_ready = 1'b0;
    @(negedge CLK); i_in_token = 1'b0;
    #2 RESET = 1'b1;
    #1;
    chk("rst_mid_valid", {31'h0, tx_valid[0]}, 32'h0);
    chk("rst_mid_busy",  {31'h0, busy[0]}, 32'h0);
    chk("rst_mid_raddr", {22'h0, raddr0}, 32'h0);
    @(negedge CLK); RESET = 1'b0; i_tx_ready = 1'b1;
    pulse_in(); #1;
    chk("rst_no_resume", {31'h0, tx_valid[0]}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
